// File: rtl/wrr_slice_arbiter_pkg.sv
// Shared definitions for the weighted round-robin slice arbiter: FSM state
// encoding, default sizes and the index helpers used for port widths and
// pointer rotation.
package wrr_slice_arbiter_pkg;

   localparam int DEF_N  = 4;
   localparam int DEF_WW = 4;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   // Number of bits needed to index v entries (v >= 2).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // (base + off) mod n, assuming base < n and off <= n.
   function automatic int rot_idx(input int base, input int off, input int n);
      int s;
      s = base + off;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/wrr_slice_arbiter_if.sv
// Requester/config side bundle of the slice arbiter. The master side is the
// requester/config agent, the slave side is the arbiter itself.
interface wrr_slice_arbiter_if
   import wrr_slice_arbiter_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int WW = DEF_WW
);
   localparam int IW = clog2(N);

   logic [N-1:0]  req;
   logic          cfg_we;
   logic [IW-1:0] cfg_idx;
   logic [WW-1:0] cfg_weight;
   logic [N-1:0]  grant;
   logic [IW-1:0] grant_id;
   logic          busy;
   logic          grant_last;

   modport master (
      output req, cfg_we, cfg_idx, cfg_weight,
      input  grant, grant_id, busy, grant_last
   );

   modport slave (
      input  req, cfg_we, cfg_idx, cfg_weight,
      output grant, grant_id, busy, grant_last
   );
endinterface

// File: rtl/wrr_slice_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping
// from N-1 back to 0. Purely combinational.
module wrr_slice_arbiter_rr_pick
   import wrr_slice_arbiter_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic [N-1:0]         req,
   input  logic [clog2(N)-1:0]  ptr,
   output logic [N-1:0]         win_oh,
   output logic [clog2(N)-1:0]  win_idx,
   output logic                 any
);
   localparam int IW = clog2(N);

   logic [IW-1:0] cand;

   // Scan candidates in rotated order; the first hit wins.
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      any     = 1'b0;
      cand    = '0;
      for (int i = 0; i < N; i++) begin
         cand = IW'(rot_idx(int'(ptr), i, N));
         if (!any && req[cand]) begin
            any           = 1'b1;
            win_idx       = cand;
            win_oh[cand]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wrr_slice_arbiter.sv
// Weighted round-robin arbiter with per-requester time slices. The owner
// keeps the grant until it drops req or its slice expires; the pointer then
// moves past it and the next winner is picked in the same edge.
module wrr_slice_arbiter
   import wrr_slice_arbiter_pkg::*;
#(
   parameter int N          = DEF_N,
   parameter int WW         = DEF_WW,
   parameter int DEF_WEIGHT = 1
) (
   input  logic                clk,
   input  logic                rst,
   wrr_slice_arbiter_if.slave  bus
);
   localparam int IW = clog2(N);

   arb_state_t    state, state_nxt;
   logic [WW-1:0] weight [N];
   logic [WW-1:0] cnt, cnt_nxt, load_cnt;
   logic [IW-1:0] ptr, ptr_nxt, pick_ptr, owner_inc;
   logic [N-1:0]  grant_q, grant_nxt;
   logic [IW-1:0] id_q, id_nxt;
   logic          busy_q, busy_nxt;
   logic          last_q, last_nxt;
   logic          term;
   logic [N-1:0]  win_oh;
   logic [IW-1:0] win_idx;
   logic          win_any;

   // A zero weight still buys one cycle so no requester can be starved.
   function automatic logic [WW-1:0] eff_weight(input logic [WW-1:0] w);
      return (w == '0) ? WW'(1) : w;
   endfunction

   wrr_slice_arbiter_rr_pick #(.N(N)) u_pick (
      .req     (bus.req),
      .ptr     (pick_ptr),
      .win_oh  (win_oh),
      .win_idx (win_idx),
      .any     (win_any)
   );

   // Slice termination and the pointer the shared picker searches from.
   always_comb begin
      owner_inc = IW'(rot_idx(int'(id_q), 1, N));
      term      = (state == ST_GRANT) && (!bus.req[id_q] || (cnt == '0));
      pick_ptr  = (state == ST_GRANT) ? owner_inc : ptr;
      load_cnt  = eff_weight(weight[win_idx]) - WW'(1);
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (win_any)          state_nxt = ST_GRANT;
         ST_GRANT: if (term && !win_any) state_nxt = ST_IDLE;
         default:                        state_nxt = ST_IDLE;
      endcase
   end

   // Next values for the slice counter, pointer and registered outputs.
   always_comb begin
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      grant_nxt = grant_q;
      id_nxt    = id_q;
      busy_nxt  = busy_q;
      last_nxt  = last_q;
      case (state)
         ST_IDLE: begin
            if (win_any) begin
               grant_nxt = win_oh;
               id_nxt    = win_idx;
               cnt_nxt   = load_cnt;
               busy_nxt  = 1'b1;
               last_nxt  = (load_cnt == '0);
            end
         end
         ST_GRANT: begin
            if (term) begin
               ptr_nxt = owner_inc;
               if (win_any) begin
                  grant_nxt = win_oh;
                  id_nxt    = win_idx;
                  cnt_nxt   = load_cnt;
                  busy_nxt  = 1'b1;
                  last_nxt  = (load_cnt == '0);
               end else begin
                  grant_nxt = '0;
                  cnt_nxt   = '0;
                  busy_nxt  = 1'b0;
                  last_nxt  = 1'b0;
               end
            end else begin
               cnt_nxt  = cnt - WW'(1);
               last_nxt = (cnt == WW'(1));
            end
         end
         default: begin
            grant_nxt = '0;
            busy_nxt  = 1'b0;
            last_nxt  = 1'b0;
         end
      endcase
   end

   // Counter, pointer and output registers; everything clears on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr     <= '0;
         cnt     <= '0;
         grant_q <= '0;
         id_q    <= '0;
         busy_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         ptr     <= ptr_nxt;
         cnt     <= cnt_nxt;
         grant_q <= grant_nxt;
         id_q    <= id_nxt;
         busy_q  <= busy_nxt;
         last_q  <= last_nxt;
      end
   end

   // Weight file; a load in the same edge as a write still sees the old value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) weight[i] <= WW'(DEF_WEIGHT);
      end else if (bus.cfg_we && (int'(bus.cfg_idx) < N)) begin
         weight[bus.cfg_idx] <= bus.cfg_weight;
      end
   end

   assign bus.grant      = grant_q;
   assign bus.grant_id   = id_q;
   assign bus.busy       = busy_q;
   assign bus.grant_last = last_q;

endmodule

// File: tb/tb_wrr_slice_arbiter.sv
// Bench for the weighted round-robin slice arbiter: directed scenarios plus a
// randomized run against a slice-accounting reference model.
module tb_wrr_slice_arbiter;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   wrr_slice_arbiter_if #(.N(4), .WW(4)) bus  ();
   wrr_slice_arbiter_if #(.N(3), .WW(4)) bus3 ();

   wrr_slice_arbiter #(.N(4), .WW(4), .DEF_WEIGHT(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   wrr_slice_arbiter #(.N(3), .WW(4), .DEF_WEIGHT(1)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the resource, how long its slice is and how
   // many cycles of it have been used so far.
   int m_owner;
   int m_len;
   int m_used;
   int m_ptr;
   int m_wt [4];

   function automatic int effw(input int w);
      return (w == 0) ? 1 : w;
   endfunction

   function automatic int pick(input logic [3:0] r, input int from);
      for (int k = 0; k < 4; k++) begin
         if (r[(from + k) % 4]) return (from + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] m_grant();
      return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
   endfunction

   function automatic logic m_last();
      return (m_owner >= 0) && (m_used == m_len);
   endfunction

   task automatic model_reset();
      m_owner = -1; m_len = 0; m_used = 0; m_ptr = 0;
      for (int i = 0; i < 4; i++) m_wt[i] = 1;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic we,
                             input logic [1:0] idx, input logic [3:0] w);
      int win;
      if (m_owner < 0) begin
         win = pick(r, m_ptr);
         if (win >= 0) begin
            m_owner = win; m_len = effw(m_wt[win]); m_used = 1;
         end
      end else if (!r[m_owner] || (m_used == m_len)) begin
         m_ptr = (m_owner + 1) % 4;
         win   = pick(r, m_ptr);
         if (win >= 0) begin
            m_owner = win; m_len = effw(m_wt[win]); m_used = 1;
         end else begin
            m_owner = -1;
         end
      end else begin
         m_used++;
      end
      if (we) m_wt[idx] = int'(w);
   endtask

   task automatic cycle(input logic [3:0] r, input logic we,
                        input logic [1:0] idx, input logic [3:0] w);
      bus.req = r; bus.cfg_we = we; bus.cfg_idx = idx; bus.cfg_weight = w;
      @(posedge clk);
      model_edge(r, we, idx, w);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.req = 4'b1111; bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_weight = '0;
      bus3.req = '0; bus3.cfg_we = 1'b0; bus3.cfg_idx = '0; bus3.cfg_weight = '0;
      model_reset();
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.grant_last !== 1'b0
             || bus.grant_id !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: grant=%b busy=%b last=%b id=%0d, want 0000/0/0/0",
                     bus.grant, bus.busy, bus.grant_last, bus.grant_id);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      cycle(4'b1111, 1'b0, 2'd0, 4'd0);
      n_cmp++;
      if (bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
         n_bad++;
         $display("FAIL first_grant: grant=%b busy=%b, want 0001/1", bus.grant, bus.busy);
      end
   endtask

   task automatic test_equal_weights();
      logic [3:0] exp_seq [4];
      exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int k = 0; k < 4; k++) begin
         cycle(4'b1111, 1'b0, 2'd0, 4'd0);
         n_cmp++;
         if (bus.grant !== exp_seq[k] || bus.grant_last !== 1'b1) begin
            n_bad++;
            $display("FAIL equal_rotation[%0d]: grant=%b last=%b, want %b/1",
                     k, bus.grant, bus.grant_last, exp_seq[k]);
         end
      end
   endtask

   task automatic test_weighted();
      int q[$];
      int pos;
      int o;
      logic exp_last;
      for (int i = 0; i < 4; i++) cycle(4'b0000, 1'b1, 2'(i), 4'(i + 1));
      // Pointer sits at 1 after requester 0's slice ended; expand by weight.
      o = 1;
      while (q.size() < 20) begin
         for (int k = 0; k < o + 1; k++) q.push_back(o);
         o = (o + 1) % 4;
      end
      pos = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(4'b1111, 1'b0, 2'd0, 4'd0);
         exp_last = (k == 19) ? (q[k] == 0) : (q[k + 1] != q[k]);
         if (q[k] == 0 && k < 19) exp_last = 1'b1;
         n_cmp++;
         if (bus.grant !== (4'b0001 << q[k]) || bus.grant_last !== exp_last) begin
            n_bad++;
            $display("FAIL weighted_slices[%0d]: grant=%b last=%b, want %b/%b",
                     k, bus.grant, bus.grant_last, 4'b0001 << q[k], exp_last);
         end
         pos++;
      end
   endtask

   task automatic test_drop();
      cycle(4'b0000, 1'b1, 2'd2, 4'd4);
      cycle(4'b0100, 1'b0, 2'd0, 4'd0);
      cycle(4'b0100, 1'b0, 2'd0, 4'd0);
      n_cmp++;
      if (bus.grant !== 4'b0100 || bus.grant_last !== 1'b0) begin
         n_bad++;
         $display("FAIL drop_held: grant=%b last=%b, want 0100/0", bus.grant, bus.grant_last);
      end
      cycle(4'b0000, 1'b0, 2'd0, 4'd0);
      n_cmp++;
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL drop_release: grant=%b busy=%b, want 0000/0", bus.grant, bus.busy);
      end
      cycle(4'b1111, 1'b0, 2'd0, 4'd0);
      n_cmp++;
      if (bus.grant !== 4'b1000 || bus.grant_id !== 2'd3) begin
         n_bad++;
         $display("FAIL drop_next_ptr: grant=%b id=%0d, want 1000/3", bus.grant, bus.grant_id);
      end
   endtask

   task automatic test_lone();
      cycle(4'b0000, 1'b0, 2'd0, 4'd0);
      cycle(4'b0000, 1'b1, 2'd1, 4'd2);
      for (int k = 1; k <= 8; k++) begin
         cycle(4'b0010, 1'b0, 2'd0, 4'd0);
         n_cmp++;
         if (bus.grant !== 4'b0010 || bus.grant_last !== ((k % 2) == 0)) begin
            n_bad++;
            $display("FAIL lone_regrant[%0d]: grant=%b last=%b, want 0010/%0d",
                     k, bus.grant, bus.grant_last, (k % 2) == 0);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic       we;
      logic [1:0] idx;
      logic [3:0] w;
      r = 4'($urandom);
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom);
         we  = ($urandom_range(0, 7) == 0);
         idx = 2'($urandom);
         w   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
         cycle(r, we, idx, w);
         n_cmp++;
         if (bus.grant !== m_grant() || bus.busy !== (m_owner >= 0)
             || bus.grant_last !== m_last()
             || (m_owner >= 0 && bus.grant_id !== 2'(m_owner))) begin
            n_bad++;
            $display("FAIL random[%0d]: grant=%b id=%0d busy=%b last=%b, want %b/%0d/%b/%b",
                     k, bus.grant, bus.grant_id, bus.busy, bus.grant_last,
                     m_grant(), m_owner, m_owner >= 0, m_last());
         end
      end
   endtask

   task automatic test_midslice_reset();
      cycle(4'b1111, 1'b0, 2'd0, 4'd0);
      cycle(4'b1111, 1'b0, 2'd0, 4'd0);
      n_cmp++;
      if (bus.busy !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_reset_busy: busy=%b, want 1", bus.busy);
      end
      #1 rst = 1'b0;
      #1;
      n_cmp++;
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.grant_last !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: grant=%b busy=%b last=%b, want 0000/0/0",
                  bus.grant, bus.busy, bus.grant_last);
      end
      #1 rst = 1'b1;
      model_reset();
      cycle(4'b0000, 1'b1, 2'd0, 4'd0);
      for (int k = 0; k < 5; k++) begin
         cycle(4'b0001, 1'b0, 2'd0, 4'd0);
         n_cmp++;
         if (bus.grant !== 4'b0001 || bus.grant_last !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_weight[%0d]: grant=%b last=%b, want 0001/1",
                     k, bus.grant, bus.grant_last);
         end
      end
   endtask

   task automatic test_idx_range();
      logic [2:0] exp_g;
      bus.req = 4'b0000; bus.cfg_we = 1'b0;
      bus3.cfg_we = 1'b1; bus3.cfg_idx = 2'd3; bus3.cfg_weight = 4'd7; bus3.req = 3'b000;
      @(posedge clk); #1;
      bus3.cfg_we = 1'b0; bus3.req = 3'b111;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         exp_g = 3'b001 << (k % 3);
         n_cmp++;
         if (bus3.grant !== exp_g || bus3.grant_last !== 1'b1) begin
            n_bad++;
            $display("FAIL idx_range[%0d]: grant=%b last=%b, want %b/1",
                     k, bus3.grant, bus3.grant_last, exp_g);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_equal_weights();
      test_weighted();
      test_drop();
      test_lone();
      test_random();
      test_midslice_reset();
      test_idx_range();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
